// File: rtl/cube_pkg.sv
// Shared constants and types for the LED-cube scan bus (driver and capture sides).
// Latency: none, declarations only.
// Backpressure: none, the scan bus is free-running.
package cube_pkg;

    localparam int WIDTH   = 8;
    localparam int HEIGHT  = 8;
    localparam int DEPTH   = 8;
    localparam int CELLS_W = WIDTH * HEIGHT * DEPTH;
    localparam int OFS_W   = $clog2(CELLS_W);

    // Pin field positions, identical to the ones cube_output drives.
    localparam int PINS_W     = 15;
    localparam int DATA_LSB   = 0;
    localparam int DATA_MSB   = 7;
    localparam int LAYER_LSB  = 8;
    localparam int LAYER_MSB  = 10;
    localparam int ROW_LSB    = 11;
    localparam int ROW_MSB    = 13;
    localparam int ENABLE_BIT = 14;

    localparam int              K_W    = 6;
    localparam logic [K_W-1:0]  K_LAST = 6'd63;

    typedef enum logic {
        HUNT = 1'b0,
        FILL = 1'b1
    } state_t;

    // One sampled bus word; en_n is the active-low enable.
    typedef struct packed {
        logic             en_n;
        logic [2:0]       row;
        logic [2:0]       layer;
        logic [WIDTH-1:0] data;
    } pins_t;

    // Address half of a bus word, held back when data trails the address.
    typedef struct packed {
        logic       en_n;
        logic [2:0] row;
        logic [2:0] layer;
    } addr_t;

    // k = layer*8 + row; storage offset = layer*WIDTH + row*WIDTH*HEIGHT.
    function automatic logic [OFS_W-1:0] cell_offset(input logic [K_W-1:0] k);
        return {k[2:0], k[5:3], 3'b000};
    endfunction

endpackage

// File: rtl/cube_scan_capture_if.sv
// Scan-bus input and captured-frame outputs of the cube scan capture block.
// Latency: none, wiring only.
// Backpressure: none, the frame consumer must accept every Frame_valid pulse.
interface cube_scan_capture_if;
    import cube_pkg::*;

    logic [PINS_W-1:0]  pins;
    logic [CELLS_W-1:0] cells;
    logic               frame_valid;
    logic               sync_error;
    logic [7:0]         frame_count;
    logic               locked;

    modport master (
        output pins,
        input  cells, frame_valid, sync_error, frame_count, locked
    );

    modport slave (
        input  pins,
        output cells, frame_valid, sync_error, frame_count, locked
    );
endinterface

// File: rtl/cube_pin_decode.sv
// Samples the scan pins and re-pairs each data byte with the layer/row it belongs to.
// Latency: beat presented combinationally after the edge that samples its data byte.
// Backpressure: none, a beat is offered every cycle whether or not it is used.
module cube_pin_decode
    import cube_pkg::*;
#(
    parameter int ADDR_LAG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PINS_W-1:0] pins,
    output logic              beat_valid,
    output logic [K_W-1:0]    beat_k,
    output logic [WIDTH-1:0]  beat_data
);

    pins_t smp;
    logic  smp_vld;
    addr_t pair_addr;
    logic  pair_vld;

    // Input sample register; the valid bit keeps the reset value from posing as a beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            smp     <= '0;
            smp_vld <= 1'b0;
        end else begin
            smp     <= '{en_n:  pins[ENABLE_BIT],
                         row:   pins[ROW_MSB:ROW_LSB],
                         layer: pins[LAYER_MSB:LAYER_LSB],
                         data:  pins[DATA_MSB:DATA_LSB]};
            smp_vld <= 1'b1;
        end
    end

    generate
        if (ADDR_LAG != 0) begin : g_lag
            addr_t lag;
            logic  lag_vld;

            // Hold the previous address so it meets the data byte that trails it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    lag     <= '0;
                    lag_vld <= 1'b0;
                end else begin
                    lag     <= {smp.en_n, smp.row, smp.layer};
                    lag_vld <= smp_vld;
                end
            end

            assign pair_addr = lag;
            assign pair_vld  = lag_vld & smp_vld;
        end else begin : g_nolag
            assign pair_addr = {smp.en_n, smp.row, smp.layer};
            assign pair_vld  = smp_vld;
        end
    endgenerate

    assign beat_valid = pair_vld & ~pair_addr.en_n;
    assign beat_k     = {pair_addr.layer, pair_addr.row};
    assign beat_data  = smp.data;

endmodule

// File: rtl/cube_scan_capture.sv
// Rebuilds 512-bit cube frames from the scan bus and publishes complete in-order frames.
// Latency: last beat sampled at edge N gives Cells/Frame_valid at edge N+1.
// Backpressure: none, scan order violations are flagged and the frame is dropped.
module cube_scan_capture
    import cube_pkg::*;
#(
    parameter int ADDR_LAG = 1
) (
    input  logic                clk,
    input  logic                reset,
    cube_scan_capture_if.slave  bus
);

    logic               beat_valid;
    logic [K_W-1:0]     beat_k;
    logic [WIDTH-1:0]   beat_data;

    state_t             state, state_nxt;
    logic [K_W-1:0]     exp_k, exp_nxt;
    logic               wr, pub, err;
    logic [CELLS_W-1:0] shadow, shadow_merged;

    cube_pin_decode #(.ADDR_LAG(ADDR_LAG)) u_decode (
        .clk        (clk),
        .reset      (reset),
        .pins       (bus.pins),
        .beat_valid (beat_valid),
        .beat_k     (beat_k),
        .beat_data  (beat_data)
    );

    // Scan-order tracking: decide write, publish and error for the current beat.
    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_k;
        wr        = 1'b0;
        pub       = 1'b0;
        err       = 1'b0;
        if (beat_valid) begin
            case (state)
                HUNT: begin
                    if (beat_k == '0) begin
                        wr        = 1'b1;
                        exp_nxt   = K_W'(1);
                        state_nxt = FILL;
                    end
                end
                FILL: begin
                    if (beat_k == exp_k) begin
                        wr = 1'b1;
                        if (beat_k == K_LAST) begin
                            pub     = 1'b1;
                            exp_nxt = '0;
                        end else begin
                            exp_nxt = exp_k + K_W'(1);
                        end
                    end else begin
                        err = 1'b1;
                        if (beat_k == '0) begin
                            wr      = 1'b1;
                            exp_nxt = K_W'(1);
                        end else begin
                            exp_nxt   = '0;
                            state_nxt = HUNT;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Shadow frame with the current beat merged in, so the last beat publishes in one cycle.
    always_comb begin
        shadow_merged = shadow;
        shadow_merged[cell_offset(beat_k) +: WIDTH] = beat_data;
    end

    // FSM state and expected scan index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HUNT;
            exp_k <= '0;
        end else begin
            state <= state_nxt;
            exp_k <= exp_nxt;
        end
    end

    // Shadow buffer needs no reset: nothing reaches Cells without a full in-order fill.
    always_ff @(posedge clk) begin
        if (wr) begin
            shadow <= shadow_merged;
        end
    end

    // Published frame, strobes and frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.cells       <= '0;
            bus.frame_valid <= 1'b0;
            bus.sync_error  <= 1'b0;
            bus.frame_count <= '0;
        end else begin
            bus.frame_valid <= pub;
            bus.sync_error  <= err;
            if (pub) begin
                bus.cells       <= shadow_merged;
                bus.frame_count <= bus.frame_count + 8'd1;
            end
        end
    end

    assign bus.locked = (state == FILL);

endmodule

// File: tb/tb_cube_scan_capture.sv
// Bench for cube_scan_capture: drives the scan bus like cube_output (data one slot behind
// its address), table of clean frames plus skip/restart/reset/wrap sequences, and a
// scoreboard of expected frames popped on every Frame_valid.
module tb_cube_scan_capture;
    import cube_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    cube_scan_capture_if bus();

    cube_scan_capture #(.ADDR_LAG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int bad    = 0;
    int se_cnt = 0;

    logic [7:0]   pend     = 8'h00;
    logic [7:0]   exp_fc   = 8'h00;
    logic [511:0] last_img = '0;

    typedef struct {
        logic [511:0] cells;
        logic [7:0]   count;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [511:0] image;
        int           blank_after;
        int           blank_len;
        logic [7:0]   exp_count;
    } vec_t;
    vec_t vecs[5];

    task automatic chk_w(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [511:0] img, input int k);
        int off;
        off = (k / 8) * 8 + (k % 8) * 64;
        return img[off +: 8];
    endfunction

    task automatic rand_img(output logic [511:0] img);
        for (int i = 0; i < 16; i++) img[i*32 +: 32] = $urandom;
    endtask

    // One bus slot: address/enable of this beat, data byte of the previous slot.
    task automatic drive_slot(input logic en_n, input int k, input logic [7:0] d);
        logic [5:0] kk;
        kk = k[5:0];
        bus.pins = {en_n, kk[2:0], kk[5:3], pend};
        pend = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_scan(input logic [511:0] img, input int lo, input int hi,
                             input int blank_after, input int blank_len);
        for (int k = lo; k <= hi; k++) begin
            drive_slot(1'b0, k, byte_of(img, k));
            if (k == blank_after)
                for (int b = 0; b < blank_len; b++) drive_slot(1'b1, k, 8'($urandom));
        end
    endtask

    task automatic flush();
        drive_slot(1'b1, 0, 8'h00);
    endtask

    task automatic expect_frame(input logic [511:0] img);
        exp_fc = exp_fc + 8'd1;
        sb_q.push_back('{cells: img, count: exp_fc});
        last_img = img;
    endtask

    // Called right after flush: publish lands exactly one edge later.
    task automatic check_latency(input string name);
        chk_i({name, "_fv_early"}, int'(bus.frame_valid), 0);
        @(posedge clk);
        #1;
        chk_i({name, "_fv_latency"}, int'(bus.frame_valid), 1);
    endtask

    // Scoreboard monitor and strobe exclusivity.
    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1 || bus.sync_error === 1'b1)
            chk_i("fv_se_exclusive", int'(bus.frame_valid & bus.sync_error), 0);
        if (bus.sync_error === 1'b1) se_cnt++;
        if (bus.frame_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_publish: got Frame_valid with count %0d, want none",
                         bus.frame_count);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk_w("sb_cells", bus.cells, e.cells);
                chk_i("sb_count", int'(bus.frame_count), int'(e.count));
            end
        end
    end

    initial begin
        logic [511:0] img_a, img_b;
        int base;

        vecs[0].image = {8{64'h0123456789abcdef}}; vecs[0].blank_after = -1; vecs[0].blank_len = 0; vecs[0].exp_count = 8'd1;
        vecs[1].image = {8{64'h0123456789abcdef}}; vecs[1].blank_after = -1; vecs[1].blank_len = 0; vecs[1].exp_count = 8'd2;
        rand_img(img_a);
        vecs[2].image = img_a;                     vecs[2].blank_after = 20; vecs[2].blank_len = 5; vecs[2].exp_count = 8'd3;
        rand_img(img_a);
        vecs[3].image = img_a;                     vecs[3].blank_after = -1; vecs[3].blank_len = 0; vecs[3].exp_count = 8'd4;
        vecs[4].image = {512{1'b1}};               vecs[4].blank_after = 0;  vecs[4].blank_len = 2; vecs[4].exp_count = 8'd5;

        bus.pins = 15'h4000;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_w("rst_cells", bus.cells, '0);
        chk_i("rst_fv", int'(bus.frame_valid), 0);
        chk_i("rst_se", int'(bus.sync_error), 0);
        chk_i("rst_fc", int'(bus.frame_count), 0);
        chk_i("rst_locked", int'(bus.locked), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Table of clean frames (loopback pattern, random, blanking).
        for (int i = 0; i < 5; i++) begin
            send_scan(vecs[i].image, 0, 63, vecs[i].blank_after, vecs[i].blank_len);
            sb_q.push_back('{cells: vecs[i].image, count: vecs[i].exp_count});
            exp_fc   = vecs[i].exp_count;
            last_img = vecs[i].image;
            flush();
            check_latency("table");
            chk_w("table_cells", bus.cells, vecs[i].image);
            chk_i("table_fc", int'(bus.frame_count), int'(vecs[i].exp_count));
            chk_i("table_locked", int'(bus.locked), 1);
        end
        chk_i("table_no_se", se_cnt, 0);

        // Skip: k=0..9 then k=11.
        rand_img(img_a);
        send_scan(img_a, 0, 9, -1, 0);
        drive_slot(1'b0, 11, 8'h5a);
        flush();
        chk_i("skip_locked_before", int'(bus.locked), 1);
        @(posedge clk);
        #1;
        chk_i("skip_se", int'(bus.sync_error), 1);
        chk_i("skip_locked", int'(bus.locked), 0);
        chk_i("skip_fv", int'(bus.frame_valid), 0);
        chk_w("skip_cells_hold", bus.cells, last_img);
        rand_img(img_b);
        send_scan(img_b, 0, 63, -1, 0);
        expect_frame(img_b);
        flush();
        check_latency("skip_recover");
        chk_i("skip_se_once", se_cnt, 1);

        // Restart: k=0..30 then a full scan.
        base = se_cnt;
        rand_img(img_a);
        rand_img(img_b);
        send_scan(img_a, 0, 30, -1, 0);
        send_scan(img_b, 0, 63, -1, 0);
        expect_frame(img_b);
        flush();
        check_latency("restart");
        chk_w("restart_cells", bus.cells, img_b);
        chk_i("restart_se_once", se_cnt, base + 1);

        // Reset mid-frame at k=40.
        rand_img(img_a);
        send_scan(img_a, 0, 39, -1, 0);
        reset = 1'b1;
        drive_slot(1'b0, 40, byte_of(img_a, 40));
        reset = 1'b0;
        chk_w("mrst_cells", bus.cells, '0);
        chk_i("mrst_fv", int'(bus.frame_valid), 0);
        chk_i("mrst_se", int'(bus.sync_error), 0);
        chk_i("mrst_fc", int'(bus.frame_count), 0);
        chk_i("mrst_locked", int'(bus.locked), 0);
        exp_fc = 8'd0;
        rand_img(img_b);
        send_scan(img_b, 0, 63, -1, 0);
        expect_frame(img_b);
        flush();
        check_latency("mrst");
        chk_i("mrst_fc_after", int'(bus.frame_count), 1);

        // Wrap: 255 more frames bring the counter to 256 publishes since reset.
        for (int f = 2; f <= 256; f++) begin
            rand_img(img_a);
            send_scan(img_a, 0, 63, -1, 0);
            expect_frame(img_a);
            flush();
        end
        @(posedge clk);
        #1;
        chk_i("wrap_fc", int'(bus.frame_count), 0);
        chk_w("wrap_cells", bus.cells, last_img);

        repeat (3) @(posedge clk);
        #1;
        chk_i("sb_drained", sb_q.size(), 0);
        chk_i("total_se", se_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
